// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding feeding the EX-stage ALU; optional macro ID_EX_LOAD_USE_EN.
// Latency: decode values loaded at edge N drive the EX outputs in cycle N+1; the forwarding muxes are combinational.
// Backpressure: stall_e holds every register, flush_e (which wins over stall_e) loads a bubble, and reset wins over both.
module id_ex_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_OP_W   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     rd1_d,
  input  logic [DATA_W-1:0]     rd2_d,
  input  logic [DATA_W-1:0]     imm_d,
  input  logic [REG_ADDR_W-1:0] rs_d,
  input  logic [REG_ADDR_W-1:0] rt_d,
  input  logic [REG_ADDR_W-1:0] rd_d,
  input  logic [ALU_OP_W-1:0]   alu_control_d,
  input  logic                  alu_src_d,
  input  logic                  reg_dst_d,
  input  logic                  reg_write_d,
  input  logic                  mem_write_d,
  input  logic                  mem_to_reg_d,
  input  logic                  valid_d,
  input  logic                  stall_e,
  input  logic                  flush_e,
  input  logic [1:0]            forward_a_e,
  input  logic [1:0]            forward_b_e,
  input  logic [DATA_W-1:0]     result_w,
  input  logic [DATA_W-1:0]     alu_out_m,
  output logic [DATA_W-1:0]     src_a_e,
  output logic [DATA_W-1:0]     src_b_e,
  output logic [ALU_OP_W-1:0]   alu_control_opr,
  output logic [DATA_W-1:0]     write_data_e,
  output logic [REG_ADDR_W-1:0] write_reg_e,
  output logic [REG_ADDR_W-1:0] rs_e,
  output logic [REG_ADDR_W-1:0] rt_e,
  output logic                  reg_write_e,
  output logic                  mem_write_e,
  output logic                  mem_to_reg_e,
`ifdef ID_EX_LOAD_USE_EN
  output logic                  load_use_stall,
`endif
  output logic                  valid_e
);

  logic [DATA_W-1:0]     rd1_q, rd2_q, imm_q;
  logic [REG_ADDR_W-1:0] rs_q, rt_q, write_reg_q;
  logic [ALU_OP_W-1:0]   alu_control_q;
  logic                  alu_src_q;
  logic                  reg_write_q, mem_write_q, mem_to_reg_q, valid_q;
  logic                  bubble;
  logic [DATA_W-1:0]     fwd_a, fwd_b;

`ifdef ID_EX_LOAD_USE_EN
  // A load in EX whose destination is read by the instruction in decode; r0 never creates a dependency.
  assign load_use_stall = valid_q & mem_to_reg_q & (rt_q != '0) &
                          ((rt_q == rs_d) | (rt_q == rt_d));
  // A flush always bubbles; a load-use bubble only applies when the stage is not being held.
  assign bubble = flush_e | (~stall_e & load_use_stall);
`else
  assign bubble = flush_e;
`endif

  // Stage register: reset clears everything, a bubble kills only the control bits, a stall holds, otherwise load.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd1_q         <= '0;
      rd2_q         <= '0;
      imm_q         <= '0;
      rs_q          <= '0;
      rt_q          <= '0;
      write_reg_q   <= '0;
      alu_control_q <= '0;
      alu_src_q     <= 1'b0;
      reg_write_q   <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      valid_q       <= 1'b0;
    end else if (bubble) begin
      write_reg_q   <= '0;
      reg_write_q   <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      valid_q       <= 1'b0;
    end else if (!stall_e) begin
      rd1_q         <= rd1_d;
      rd2_q         <= rd2_d;
      imm_q         <= imm_d;
      rs_q          <= rs_d;
      rt_q          <= rt_d;
      write_reg_q   <= reg_dst_d ? rd_d : rt_d;
      alu_control_q <= alu_control_d;
      alu_src_q     <= alu_src_d;
      reg_write_q   <= reg_write_d;
      mem_write_q   <= mem_write_d;
      mem_to_reg_q  <= mem_to_reg_d;
      valid_q       <= valid_d;
    end
  end

  // Forwarding muxes; the reserved select and any unknown select fall back to the register value.
  always_comb begin
    fwd_a = rd1_q;
    fwd_b = rd2_q;
    case (forward_a_e)
      2'b01:   fwd_a = result_w;
      2'b10:   fwd_a = alu_out_m;
      default: fwd_a = rd1_q;
    endcase
    case (forward_b_e)
      2'b01:   fwd_b = result_w;
      2'b10:   fwd_b = alu_out_m;
      default: fwd_b = rd2_q;
    endcase
  end

  assign src_a_e         = fwd_a;
  assign src_b_e         = alu_src_q ? imm_q : fwd_b;
  // Store data is always the forwarded rt value, even when the ALU takes the immediate.
  assign write_data_e    = fwd_b;
  assign alu_control_opr = alu_control_q;
  assign write_reg_e     = write_reg_q;
  assign rs_e            = rs_q;
  assign rt_e            = rt_q;
  assign reg_write_e     = reg_write_q;
  assign mem_write_e     = mem_write_q;
  assign mem_to_reg_e    = mem_to_reg_q;
  assign valid_e         = valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load, immediate select, forwarding, stall/flush, load-use, mid-stream reset.
// Inputs change 1 ns after the rising edge; outputs are compared at that same offset.
// Builds with or without ID_EX_LOAD_USE_EN; the load-use scenario adapts to the configuration.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rd1_d, rd2_d, imm_d;
  logic [4:0]  rs_d, rt_d, rd_d;
  logic [3:0]  alu_control_d;
  logic        alu_src_d, reg_dst_d, reg_write_d, mem_write_d, mem_to_reg_d, valid_d;
  logic        stall_e, flush_e;
  logic [1:0]  forward_a_e, forward_b_e;
  logic [31:0] result_w, alu_out_m;
  logic [31:0] src_a_e, src_b_e, write_data_e;
  logic [3:0]  alu_control_opr;
  logic [4:0]  write_reg_e, rs_e, rt_e;
  logic        reg_write_e, mem_write_e, mem_to_reg_e, valid_e;
`ifdef ID_EX_LOAD_USE_EN
  logic        load_use_stall;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d),
    .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
    .alu_control_d(alu_control_d), .alu_src_d(alu_src_d), .reg_dst_d(reg_dst_d),
    .reg_write_d(reg_write_d), .mem_write_d(mem_write_d), .mem_to_reg_d(mem_to_reg_d),
    .valid_d(valid_d), .stall_e(stall_e), .flush_e(flush_e),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .result_w(result_w), .alu_out_m(alu_out_m),
    .src_a_e(src_a_e), .src_b_e(src_b_e), .alu_control_opr(alu_control_opr),
    .write_data_e(write_data_e), .write_reg_e(write_reg_e),
    .rs_e(rs_e), .rt_e(rt_e),
    .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .mem_to_reg_e(mem_to_reg_e),
`ifdef ID_EX_LOAD_USE_EN
    .load_use_stall(load_use_stall),
`endif
    .valid_e(valid_e)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    rd1_d = '0; rd2_d = '0; imm_d = '0; rs_d = '0; rt_d = '0; rd_d = '0;
    alu_control_d = '0; alu_src_d = 0; reg_dst_d = 0; reg_write_d = 0;
    mem_write_d = 0; mem_to_reg_d = 0; valid_d = 0; stall_e = 0; flush_e = 0;
    forward_a_e = 2'b00; forward_b_e = 2'b00; result_w = '0; alu_out_m = '0;
  endtask

  task automatic test_reset();
    set_idle();
    rd1_d = 32'hDEAD; rd2_d = 32'hBEEF; valid_d = 1; reg_write_d = 1; rt_d = 5'd3;
    reset = 1;
    tick(); tick();
    checks++; if ({src_a_e, src_b_e, write_data_e} !== 96'h0) begin errors++;
      $display("FAIL reset_data got %h %h %h want 0 0 0", src_a_e, src_b_e, write_data_e); end
    checks++; if ({alu_control_opr, write_reg_e, rs_e, rt_e} !== 19'h0) begin errors++;
      $display("FAIL reset_fields got %h %h %h %h want 0", alu_control_opr, write_reg_e, rs_e, rt_e); end
    checks++; if ({valid_e, reg_write_e, mem_write_e, mem_to_reg_e} !== 4'b0000) begin errors++;
      $display("FAIL reset_ctrl got %b%b%b%b want 0000", valid_e, reg_write_e, mem_write_e, mem_to_reg_e); end
    set_idle();
    reset = 0;
    tick();
    checks++; if (valid_e !== 1'b0) begin errors++; $display("FAIL post_reset_valid got %b want 0", valid_e); end
    rd1_d = 32'd5; rd2_d = 32'd7; alu_src_d = 0; valid_d = 1; reg_write_d = 1;
    alu_control_d = 4'd3; rs_d = 5'd1; rt_d = 5'd2; rd_d = 5'd8; reg_dst_d = 0;
    tick();
    checks++; if (src_a_e !== 32'd5) begin errors++; $display("FAIL load_src_a got %h want 5", src_a_e); end
    checks++; if (src_b_e !== 32'd7) begin errors++; $display("FAIL load_src_b got %h want 7", src_b_e); end
    checks++; if ({valid_e, reg_write_e, alu_control_opr} !== 6'b11_0011) begin errors++;
      $display("FAIL load_ctrl got %b%b %h want 11 3", valid_e, reg_write_e, alu_control_opr); end
    checks++; if ({rs_e, rt_e, write_reg_e} !== {5'd1, 5'd2, 5'd2}) begin errors++;
      $display("FAIL load_regs got %0d %0d %0d want 1 2 2", rs_e, rt_e, write_reg_e); end
  endtask

  task automatic test_immediate();
    alu_src_d = 1; imm_d = 32'hFFFF_FFFC; reg_dst_d = 1; rd_d = 5'd9; alu_control_d = 4'hA;
    tick();
    checks++; if (src_b_e !== 32'hFFFF_FFFC) begin errors++; $display("FAIL imm_src_b got %h want fffffffc", src_b_e); end
    checks++; if (write_data_e !== 32'd7) begin errors++; $display("FAIL imm_wdata got %h want 7", write_data_e); end
    checks++; if (write_reg_e !== 5'd9) begin errors++; $display("FAIL imm_wreg got %0d want 9", write_reg_e); end
    checks++; if (alu_control_opr !== 4'hA) begin errors++; $display("FAIL imm_aluop got %h want a", alu_control_opr); end
  endtask

  task automatic test_forwarding();
    alu_src_d = 0; rd1_d = 32'd5; rd2_d = 32'd7;
    tick();
    forward_a_e = 2'b10; alu_out_m = 32'h1234; #1;
    checks++; if (src_a_e !== 32'h1234) begin errors++; $display("FAIL fwd_a_mem got %h want 1234", src_a_e); end
    checks++; if (src_b_e !== 32'd7) begin errors++; $display("FAIL fwd_b_reg got %h want 7", src_b_e); end
    forward_b_e = 2'b01; result_w = 32'hAB; #1;
    checks++; if (src_b_e !== 32'hAB) begin errors++; $display("FAIL fwd_b_wb got %h want ab", src_b_e); end
    checks++; if (write_data_e !== 32'hAB) begin errors++; $display("FAIL fwd_wdata_wb got %h want ab", write_data_e); end
    forward_a_e = 2'b11; #1;
    checks++; if (src_a_e !== 32'd5) begin errors++; $display("FAIL fwd_a_reserved got %h want 5", src_a_e); end
    forward_a_e = 2'b01; #1;
    checks++; if (src_a_e !== 32'hAB) begin errors++; $display("FAIL fwd_a_wb got %h want ab", src_a_e); end
    alu_src_d = 1; imm_d = 32'h40;
    tick();
    checks++; if ({src_b_e, write_data_e} !== {32'h40, 32'hAB}) begin errors++;
      $display("FAIL fwd_imm_store got %h %h want 40 ab", src_b_e, write_data_e); end
    forward_a_e = 2'b00; forward_b_e = 2'b00; alu_src_d = 0;
  endtask

  task automatic test_stall_flush();
    rd1_d = 32'h11; rd2_d = 32'h22; rs_d = 5'd5; rt_d = 5'd6; rd_d = 5'd7; reg_dst_d = 1;
    valid_d = 1; reg_write_d = 1; mem_write_d = 0; alu_control_d = 4'd2; alu_src_d = 0;
    tick();
    stall_e = 1;
    for (int i = 0; i < 3; i++) begin
      rd1_d = 32'h100 + i; rd2_d = 32'h200 + i; rs_d = 5'd20 + 5'(i); rd_d = 5'd12; valid_d = 0;
      tick();
      checks++; if ({src_a_e, src_b_e, rs_e, write_reg_e, valid_e} !== {32'h11, 32'h22, 5'd5, 5'd7, 1'b1}) begin
        errors++; $display("FAIL stall_hold[%0d] got %h %h %0d %0d %b want 11 22 5 7 1",
                           i, src_a_e, src_b_e, rs_e, write_reg_e, valid_e); end
    end
    forward_a_e = 2'b10; alu_out_m = 32'h77; #1;
    checks++; if (src_a_e !== 32'h77) begin errors++; $display("FAIL stall_fwd got %h want 77", src_a_e); end
    forward_a_e = 2'b00;
    mem_write_d = 1; valid_d = 1; flush_e = 1;
    tick();
    checks++; if ({valid_e, reg_write_e, mem_write_e, mem_to_reg_e} !== 4'b0000) begin errors++;
      $display("FAIL stall_flush_ctrl got %b%b%b%b want 0000", valid_e, reg_write_e, mem_write_e, mem_to_reg_e); end
    checks++; if (write_reg_e !== 5'd0) begin errors++; $display("FAIL stall_flush_wreg got %0d want 0", write_reg_e); end
    stall_e = 0;
    tick();
    checks++; if ({valid_e, mem_write_e} !== 2'b00) begin errors++;
      $display("FAIL flush_only got %b%b want 00", valid_e, mem_write_e); end
    flush_e = 0;
  endtask

  task automatic test_load_use();
    set_idle();
    valid_d = 1; mem_to_reg_d = 1; reg_write_d = 1; rt_d = 5'd4; rs_d = 5'd2;
    tick();
    mem_to_reg_d = 0; rs_d = 5'd4; rt_d = 5'd1; rd1_d = 32'h99;
`ifdef ID_EX_LOAD_USE_EN
    #1;
    checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL lu_detect got %b want 1", load_use_stall); end
    tick();
    checks++; if ({valid_e, reg_write_e, mem_to_reg_e, write_reg_e} !== 8'h00) begin errors++;
      $display("FAIL lu_bubble got %b%b%b %0d want 000 0", valid_e, reg_write_e, mem_to_reg_e, write_reg_e); end
    checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL lu_drop got %b want 0", load_use_stall); end
    tick();
    checks++; if ({valid_e, rs_e, src_a_e} !== {1'b1, 5'd4, 32'h99}) begin errors++;
      $display("FAIL lu_resume got %b %0d %h want 1 4 99", valid_e, rs_e, src_a_e); end
    mem_to_reg_d = 1; rt_d = 5'd0; rs_d = 5'd3;
    tick();
    mem_to_reg_d = 0; rs_d = 5'd0; rt_d = 5'd0; #1;
    checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL lu_r0 got %b want 0", load_use_stall); end
    tick();
    checks++; if (valid_e !== 1'b1) begin errors++; $display("FAIL lu_r0_valid got %b want 1", valid_e); end
`else
    tick();
    checks++; if ({valid_e, reg_write_e, src_a_e} !== {1'b1, 1'b1, 32'h99}) begin errors++;
      $display("FAIL no_lu_bubble got %b%b %h want 11 99", valid_e, reg_write_e, src_a_e); end
`endif
  endtask

  task automatic test_reset_midstream();
    set_idle();
    valid_d = 1; reg_write_d = 1; reg_dst_d = 1;
    for (int i = 0; i < 3; i++) begin
      rd1_d = 32'(i * 3 + 1); rd_d = 5'(i + 10);
      tick();
      checks++; if ({src_a_e, write_reg_e} !== {32'(i * 3 + 1), 5'(i + 10)}) begin errors++;
        $display("FAIL stream[%0d] got %h %0d want %h %0d", i, src_a_e, write_reg_e, i * 3 + 1, i + 10); end
    end
    stall_e = 1; reset = 1;
    tick();
    checks++; if ({src_a_e, src_b_e, write_data_e, alu_control_opr, write_reg_e} !== 105'h0) begin errors++;
      $display("FAIL midreset_data got %h %h %h %h %0d want 0", src_a_e, src_b_e, write_data_e, alu_control_opr, write_reg_e); end
    checks++; if ({valid_e, reg_write_e, mem_write_e, mem_to_reg_e} !== 4'b0000) begin errors++;
      $display("FAIL midreset_ctrl got %b%b%b%b want 0000", valid_e, reg_write_e, mem_write_e, mem_to_reg_e); end
    reset = 0; stall_e = 0;
    rd1_d = 32'h55; rd2_d = 32'h66; rt_d = 5'd3; reg_dst_d = 0;
    tick();
    checks++; if ({src_a_e, src_b_e, valid_e, write_reg_e} !== {32'h55, 32'h66, 1'b1, 5'd3}) begin errors++;
      $display("FAIL resume got %h %h %b %0d want 55 66 1 3", src_a_e, src_b_e, valid_e, write_reg_e); end
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_forwarding();
    test_stall_flush();
    test_load_use();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
